// File: rtl/sprite_reg_bank_pkg.sv
// Shared definitions for the sprite register bank.
// Holds the per-sprite field offsets, the global-entry offsets that follow
// the sprite block, the status-page indices and the function that locates
// the global entries for a given sprite count.
package sprite_pkg;

    // Field offsets inside one 4-entry sprite slot
    localparam int POS_X = 0;
    localparam int POS_Y = 1;
    localparam int ROT   = 2;
    localparam int ATTR  = 3;

    // Offsets of the global entries relative to glob_base()
    localparam int GLB_MAP_X = 0;
    localparam int GLB_MAP_Y = 1;
    localparam int GLB_CTRL  = 2;

    // Status-page indices
    localparam int ST_MAP   = 0;
    localparam int ST_ROT   = 1;
    localparam int ST_FRAME = 2;
    localparam int ST_PEND  = 3;

    // First global entry sits right after the last sprite slot
    function automatic int glob_base(input int num_sprites);
        return 4 * num_sprites;
    endfunction

endpackage

// File: rtl/sprite_reg_bank_if.sv
// CPU register bus for the sprite register bank.
// Signals: reg_addr (address, top bit = status page), in (write data),
// we (write strobe), out (combinational read data).
// Modports: master drives the bus (CPU/testbench), slave is the bank.
interface sprite_reg_bank_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] in;
    logic              we;
    logic [DATA_W-1:0] out;

    modport master (output reg_addr, output in, output we, input out);
    modport slave  (input reg_addr, input in, input we, output out);
endinterface

// File: rtl/sprite_reg_bank_frame_ctr.sv
// sprite_frame_ctr: frame counter plus vsync-gated commit pulse.
// Ports: clk, reset_n (async active-low), vsync (frame pulse),
// work_done (CPU finished the frame), frame_cnt (wrapping vsync count),
// commit (one-cycle pulse the cycle after a vsync that saw work_done=1).
module sprite_frame_ctr #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vsync,
    input  logic              work_done,
    output logic [DATA_W-1:0] frame_cnt,
    output logic              commit
);

    logic [DATA_W-1:0] frame_cnt_r;
    logic              commit_r;

    // Count frames (natural wrap) and register the commit decision
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_r <= {DATA_W{1'b0}};
            commit_r    <= 1'b0;
        end else begin
            if (vsync) begin
                frame_cnt_r <= frame_cnt_r + {{(DATA_W-1){1'b0}}, 1'b1};
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
            commit_r <= vsync & work_done;
        end
    end

    assign frame_cnt = frame_cnt_r;
    assign commit    = commit_r;

endmodule

// File: rtl/sprite_reg_bank.sv
// sprite_reg_bank: CPU-written sprite/map register bank feeding a renderer.
// Ports: clk, reset_n (async active-low), bus (sprite_reg_bank_if.slave:
// reg_addr/in/we/out), vsync, map_data, player_rot, live_regs (flattened
// renderer view, entry i at [i*DATA_W +: DATA_W]), commit (update pulse).
// Configuration: define SPRITE_DBLBUF_EN for a shadow/live double buffer
// swapped on vsync; otherwise the renderer sees the shadow copy directly.
module sprite_reg_bank
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = 5,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 6
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    sprite_reg_bank_if.slave                      bus,
    input  logic                                  vsync,
    input  logic                                  map_data,
    input  logic [1:0]                            player_rot,
    output logic [(4*NUM_SPRITES+2)*DATA_W-1:0]   live_regs,
    output logic                                  commit
);

    localparam int NUM_ENT = glob_base(NUM_SPRITES) + 2;
    localparam int IW      = ADDR_W - 1;
    localparam logic [IW-1:0] ENT_LIM = IW'(NUM_ENT);
    localparam logic [IW-1:0] CTRL_A  = IW'(glob_base(NUM_SPRITES) + GLB_CTRL);

    logic [DATA_W-1:0] shadow_r [NUM_ENT];
    logic              work_done_r;
    logic [DATA_W-1:0] frame_cnt_s;
    logic              page_s;
    logic [IW-1:0]     idx_s;
    logic              wr_ent_s;
    logic              wr_ctrl_s;
    logic              commit_now_s;

    assign page_s       = bus.reg_addr[ADDR_W-1];
    assign idx_s        = bus.reg_addr[IW-1:0];
    assign wr_ent_s     = bus.we & ~page_s & (idx_s < ENT_LIM);
    assign wr_ctrl_s    = bus.we & ~page_s & (idx_s == CTRL_A);
    assign commit_now_s = vsync & work_done_r;

    // Shadow copy: CPU writes land here on the same edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ENT; i++) begin
                shadow_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_ent_s) begin
            shadow_r[idx_s] <= bus.in;
        end else begin
            shadow_r <= shadow_r;
        end
    end

    // work_done: a committing vsync clears it even if ctrl is written that cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            work_done_r <= 1'b0;
        end else if (commit_now_s) begin
            work_done_r <= 1'b0;
        end else if (wr_ctrl_s) begin
            work_done_r <= bus.in[0];
        end else begin
            work_done_r <= work_done_r;
        end
    end

    sprite_frame_ctr #(
        .DATA_W (DATA_W)
    ) u_frame_ctr (
        .clk       (clk),
        .reset_n   (reset_n),
        .vsync     (vsync),
        .work_done (work_done_r),
        .frame_cnt (frame_cnt_s),
        .commit    (commit)
    );

`ifdef SPRITE_DBLBUF_EN
    logic [DATA_W-1:0] live_r [NUM_ENT];

    // Live copy: loads the pre-edge shadow values on a committing vsync
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ENT; i++) begin
                live_r[i] <= {DATA_W{1'b0}};
            end
        end else if (commit_now_s) begin
            live_r <= shadow_r;
        end else begin
            live_r <= live_r;
        end
    end

    for (genvar g = 0; g < NUM_ENT; g++) begin : g_live
        assign live_regs[g*DATA_W +: DATA_W] = live_r[g];
    end
`else
    for (genvar g = 0; g < NUM_ENT; g++) begin : g_live
        assign live_regs[g*DATA_W +: DATA_W] = shadow_r[g];
    end
`endif

    // CPU read mux: shadow/ctrl on the regular page, live status on the other
    always_comb begin
        bus.out = {DATA_W{1'b0}};
        if (!page_s) begin
            if (idx_s < ENT_LIM) begin
                bus.out = shadow_r[idx_s];
            end else if (idx_s == CTRL_A) begin
                bus.out = {{(DATA_W-1){1'b0}}, work_done_r};
            end else begin
                bus.out = {DATA_W{1'b0}};
            end
        end else begin
            case (idx_s)
                IW'(ST_MAP):   bus.out = {{(DATA_W-1){1'b0}}, map_data};
                IW'(ST_ROT):   bus.out = {{(DATA_W-2){1'b0}}, player_rot};
                IW'(ST_FRAME): bus.out = frame_cnt_s;
                IW'(ST_PEND):  bus.out = {{(DATA_W-1){1'b0}}, work_done_r};
                default:       bus.out = {DATA_W{1'b0}};
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_reg_bank.sv
// Self-checking bench for sprite_reg_bank: directed scenarios plus random
// traffic compared against a register-array model of the bank.
module tb_sprite_reg_bank;

    localparam int NS = 5;
    localparam int DW = 8;
    localparam int AW = 6;
    localparam int NE = 4 * NS + 2;
    localparam int CTRL = 4 * NS + 2;
`ifdef SPRITE_DBLBUF_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    logic vsync;
    logic map_data;
    logic [1:0] player_rot;
    logic [NE*DW-1:0] live_regs;
    logic commit;

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [7:0] sh [NE];
    logic [7:0] lv [NE];
    bit wd;
    int fc;
    bit exp_commit;

    sprite_reg_bank_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sprite_reg_bank #(.NUM_SPRITES(NS), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus.slave),
        .vsync      (vsync),
        .map_data   (map_data),
        .player_rot (player_rot),
        .live_regs  (live_regs),
        .commit     (commit)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [191:0] model_live();
        logic [191:0] v = '0;
        for (int i = 0; i < NE; i++) v[i*8 +: 8] = DBL ? lv[i] : sh[i];
        return v;
    endfunction

    function automatic logic [7:0] model_read(input int a);
        int idx = a % 32;
        if (a >= 32) begin
            if (idx == 0) return {7'd0, map_data};
            if (idx == 1) return {6'd0, player_rot};
            if (idx == 2) return fc[7:0];
            if (idx == 3) return {7'd0, wd};
            return 8'd0;
        end
        if (idx < NE) return sh[idx];
        if (idx == CTRL) return {7'd0, wd};
        return 8'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NE; i++) begin
            sh[i] = 8'd0;
            lv[i] = 8'd0;
        end
        wd = 1'b0;
        fc = 0;
        exp_commit = 1'b0;
    endtask

    // one clock: drive inputs, advance the model, check commit and live bank
    task automatic step(input bit w, input int a, input int d, input bit vs);
        bit cn;
        int idx;
        bus.we = w;
        bus.reg_addr = a[5:0];
        bus.in = d[7:0];
        vsync = vs;
        @(posedge clk);
        cn = vs && wd;
        idx = a % 32;
        if (cn) for (int i = 0; i < NE; i++) lv[i] = sh[i];
        if (w && a < 32 && idx < NE) sh[idx] = d[7:0];
        if (cn) wd = 1'b0;
        else if (w && a < 32 && idx == CTRL) wd = d[0];
        if (vs) fc = (fc + 1) % 256;
        exp_commit = cn;
        #1;
        check("commit", {191'd0, commit}, {191'd0, exp_commit});
        check("live_regs", {16'd0, live_regs}, model_live());
        bus.we = 1'b0;
        vsync = 1'b0;
    endtask

    task automatic rd(input string tag, input int a);
        bus.reg_addr = a[5:0];
        #1;
        check(tag, {184'd0, bus.out}, {184'd0, model_read(a)});
    endtask

    initial begin
        reset_n = 1'b0;
        vsync = 1'b0;
        map_data = 1'b0;
        player_rot = 2'd0;
        bus.we = 1'b0;
        bus.reg_addr = '0;
        bus.in = '0;
        model_reset();
        #1;
        check("reset_commit", {191'd0, commit}, 192'd0);
        check("reset_live", {16'd0, live_regs}, 192'd0);
        rd("reset_rd0", 0);
        rd("reset_frame", 34);
        @(negedge clk);
        reset_n = 1'b1;

        // sprite0 x write; renderer view follows the model
        step(1, 0, 8'h2A, 0);
        rd("rd_s0x", 0);
        check("live0_before_commit", {184'd0, live_regs[7:0]}, {184'd0, (DBL ? 8'h00 : 8'h2A)});

        // set work_done and commit
        step(1, CTRL, 1, 0);
        rd("rd_ctrl_set", CTRL);
        step(0, 0, 0, 1);
        check("live0_after_commit", {184'd0, live_regs[7:0]}, 192'h2A);
        rd("rd_ctrl_cleared", CTRL);
        rd("rd_frame1", 34);
        step(0, 0, 0, 0);

        // skipped frame: sprite1 y written, no work_done
        step(1, 5, 8'h10, 0);
        step(0, 0, 0, 1);
        rd("rd_frame2", 34);

        // write coinciding with committing vsync
        step(1, CTRL, 1, 0);
        step(1, 10, 3, 1);
        rd("rd_s2rot", 10);
        step(1, CTRL, 1, 0);
        step(0, 0, 0, 1);
        check("live10_next", {184'd0, live_regs[10*8 +: 8]}, 192'd3);

        // ctrl write racing a committing vsync: clear wins
        step(1, CTRL, 1, 0);
        step(1, CTRL, 1, 1);
        rd("rd_pend_race", 35);

        // ignored writes: unused regular and status page
        step(1, 30, 8'h55, 0);
        step(1, 32, 8'h66, 0);
        rd("rd_unused", 30);
        rd("rd_status_map", 32);
        map_data = 1'b1;
        player_rot = 2'd2;
        rd("rd_map_data", 32);
        rd("rd_player_rot", 33);
        rd("rd_status_other", 40);

        // frame counter wrap
        while (fc != 255) step(0, 0, 0, 1);
        rd("rd_frame_ff", 34);
        step(0, 0, 0, 1);
        rd("rd_frame_wrap", 34);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            int a;
            a = $urandom_range(0, 63);
            if ($urandom_range(0, 4) == 0) a = CTRL;
            map_data = 1'($urandom_range(0, 1));
            player_rot = 2'($urandom_range(0, 3));
            step(1'($urandom_range(0, 1)), a, $urandom_range(0, 255),
                 $urandom_range(0, 3) == 0);
            rd("rd_random", $urandom_range(0, 63));
        end

        // reset mid-frame with work pending
        step(1, 3, 8'h77, 0);
        step(1, CTRL, 1, 0);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("midreset_live", {16'd0, live_regs}, model_live());
        check("midreset_commit", {191'd0, commit}, 192'd0);
        rd("midreset_rd3", 3);
        rd("midreset_pend", 35);
        rd("midreset_frame", 34);
        @(negedge clk);
        reset_n = 1'b1;
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        rd("post_reset_frame", 34);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sprite_reg_bank.md
SPRITE_REG_BANK -- requirements
Module: sprite_reg_bank

Interface
REQ-001 SHALL have parameter NUM_SPRITES, default 5, number of sprite slots (1..7).
REQ-002 SHALL have parameter DATA_W, default 8, register width (>=8).
REQ-003 SHALL have parameter ADDR_W, default 6, bus address width; bit ADDR_W-1 selects the status page.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port reg_addr  in  ADDR_W  CPU register address.
REQ-007 SHALL have port in  in  DATA_W  CPU write data.
REQ-008 SHALL have port we  in  1  CPU write strobe.
REQ-009 SHALL have port out  out  DATA_W  CPU read data, combinational.
REQ-010 SHALL have port vsync  in  1  one-cycle frame-boundary pulse.
REQ-011 SHALL have port map_data  in  1  world map tile bit.
REQ-012 SHALL have port player_rot  in  2  player desired rotation.
REQ-013 SHALL have port live_regs  out  (4*NUM_SPRITES+2)*DATA_W  flattened live bank for the renderer, entry i at bits [i*DATA_W +: DATA_W].
REQ-014 SHALL have port commit  out  1  one-cycle pulse when the live bank was updated.

Function
REQ-015 Regular page (addr[ADDR_W-1]=0): entry 4*s+f is sprite s field f (0 pos x, 1 pos y, 2 rot, 3 attr: bit0 enable); entry 4*NUM_SPRITES is map x, +1 map y, +2 ctrl (bit0 work_done).
REQ-016 Entries 0..4*NUM_SPRITES+1 SHALL exist as shadow (CPU view) and live (renderer view) copies; ctrl exists once.
REQ-017 A write with we=1 to a valid regular-page entry SHALL update the shadow copy on the same edge; writes to unused regular-page addresses or any status-page address SHALL be ignored.
REQ-018 Regular-page reads SHALL return the shadow copy; unused addresses read 0.
REQ-019 Status page: 0 -> {0,map_data}; 1 -> {0,player_rot}; 2 -> frame counter; 3 -> {0,pending} where pending = work_done; others read 0.
REQ-020 Frame counter SHALL be DATA_W bits, increment on each vsync, wrap from all-ones to 0.
REQ-021 On vsync with work_done=1 (value before the edge): all live entries SHALL load their shadow values, work_done SHALL clear, commit SHALL assert on the next cycle for exactly one cycle.
REQ-022 On vsync with work_done=0: live bank unchanged, commit stays 0 (frame skipped, counter still increments).
REQ-023 Write and vsync in the same cycle: commit SHALL copy pre-edge shadow values; the write lands in shadow only and appears in live at the next commit.
REQ-024 Write of ctrl bit0=1 coinciding with a committing vsync: clear due to commit SHALL take priority; work_done reads 0 afterwards.
REQ-025 Latency: shadow write visible on out the next cycle; live_regs change one edge after committing vsync.

Reset
REQ-026 reset_n=0 SHALL asynchronously clear all shadow, live, ctrl and frame counter registers and commit to 0; out then reflects zeroed registers and inputs.
REQ-027 Reset asserted mid-frame SHALL discard pending work; no commit pulse follows release until a new work_done+vsync.

Configuration
REQ-028 Macro SPRITE_DBLBUF_EN defined: double-buffered behaviour of REQ-016..REQ-024.
REQ-029 Macro SPRITE_DBLBUF_EN undefined: no live copy; live_regs SHALL be driven from shadow directly (writes visible next cycle), commit SHALL pulse one cycle after any vsync with work_done=1, and work_done still clears there.

Structure
REQ-030 Shared package sprite_pkg SHALL hold field offsets (POS_X, POS_Y, ROT, ATTR), status-page indices, and global-entry offset function of NUM_SPRITES.
REQ-031 Sub-module sprite_frame_ctr SHALL implement the frame counter and vsync-gated commit pulse.

Verification
REQ-032 Write 0x2A to addr 0 (sprite0 x), read addr 0 -> 0x2A; live_regs[7:0] stays 0 before any commit.
REQ-033 Set ctrl (addr 22)=1, pulse vsync -> live_regs[7:0]=0x2A, commit one-cycle pulse, addr 22 reads 0, addr 0x22 reads 1.
REQ-034 vsync with work_done=0 after writing sprite1 y=0x10 -> live entry 5 unchanged, no commit, frame count increments.
REQ-035 Write sprite2 rot=3 in the same cycle as committing vsync -> live entry 10 keeps old value; committed next frame.
REQ-036 255 vsyncs then one more -> status addr 0x22 reads 0xFF then 0x00.
REQ-037 Assert reset_n mid-frame with work_done=1 -> all registers 0, no commit on following vsync.
